shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Parametrised sequential shift-and-add multiplier with integrated control FSM, valid/ready handshakes on both sides, per-operation signed/unsigned mode and synchronous abort. It is the next-generation multiply unit for the serial arithmetic datapath. It processes one multiplier bit per clock, for any width including non-power-of-two. The result is held until the consumer accepts it.

## Interface
- NB_DATA, default 8: operand width in bits; legal range ≥ 2, any integer value.
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous abort; returns the block to IDLE from any state.
- i_valid  in  1  operand request.
- o_ready  out  1  block can accept operands.
- i_a  in  NB_DATA  multiplicand.
- i_b  in  NB_DATA  multiplier.
- i_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- o_busy  out  1  multiplication in progress.
- o_valid  out  1  o_product is valid.
- i_ready  in  1  consumer accepts the product.
- o_product  out  2*NB_DATA  result; two's complement when the captured mode is signed.

## Operation
- **States:** IDLE, MULT, DONE.
- **IDLE:**
  - o_ready = 1.
  - When i_valid is 1, the block accepts at the edge, captures operands and mode, clears the counter, clears the accumulator, and goes to MULT.
- **Signed handling at capture:**
  - Store |i_a| and |i_b| as NB_DATA-bit unsigned values. |−2^(NB_DATA−1)| = 2^(NB_DATA−1) fits.
  - Store neg = i_a[MSB] ^ i_b[MSB].
  - In unsigned mode, store operands as-is and set neg = 0.
- **MULT, one step per cycle:**
  - If the current multiplier LSB is 1, add the multiplicand to the upper NB_DATA bits of the 2·NB_DATA accumulator. The sum is NB_DATA+1 bits wide.
  - Shift {carry, accumulator} right one place and shift the multiplier right one place.
  - The counter has width $clog2(NB_DATA), with a minimum of 1 bit, and increments each step.
- **Last step (counter == NB_DATA−1):**
  - The final accumulator value, negated in two's complement if neg = 1, is written to o_product.
  - State goes to DONE.
  - Termination is an explicit compare against NB_DATA−1, never a counter overflow or all-ones test.
- **No early termination:** zero operands still take the full NB_DATA steps.
- **DONE:**
  - o_valid = 1 and o_product is held stable.
  - When i_ready is 1, the product is consumed at the edge and the state goes to IDLE.
- **Ignored inputs:** i_valid, i_a, i_b and i_signed are ignored outside IDLE. Captured values are unaffected by input changes during MULT or DONE.
- **i_clear:**
  - Any state goes to IDLE at the next edge, o_valid drops, and o_product is cleared to 0.
  - i_clear has priority over acceptance and consumption in the same cycle; no operation is accepted.
- **Output decode:**
  - o_busy = (state == MULT).
  - o_valid = (state == DONE).
  - o_ready = (state == IDLE) && !i_rst.

## Timing
- **Reset values:** state IDLE, o_ready 0 while i_rst is high, o_busy 0, o_valid 0, o_product 0, counter 0.
- **Reset deassertion:** o_ready is 1 in the first cycle after i_rst deasserts.
- **Reset mid-operation:** an in-flight result is discarded immediately (asynchronous).
- **Latency:** with acceptance at edge E0, MULT steps occur at E1..E_NB_DATA, and o_valid is high after edge E_NB_DATA. Latency is NB_DATA cycles.
- **Throughput:** with i_ready held high, one result per NB_DATA+2 cycles (IDLE 1, MULT NB_DATA, DONE 1).
- **Backpressure:** DONE persists indefinitely while i_ready is 0. o_product must not change.
- **Handshake timing:** o_ready drops the cycle after acceptance, and rises the cycle after consumption or clear.
- **Combinational paths:** o_valid, o_ready and o_busy must not depend combinationally on i_valid or i_ready. The only combinational path allowed is i_rst to o_ready.

## Test plan
- **Unsigned, NB_DATA=8:**
  - i_a = 0xFF, i_b = 0xFF, i_signed = 0 → o_product = 0xFE01, with o_valid 8 cycles after acceptance.
  - i_a = 0xFD, i_b = 0x05 → 0x04F1.
- **Signed, NB_DATA=8:**
  - −128 × −128 → 0x4000.
  - −3 × 5 (0xFD, 0x05) → 0xFFF1.
  - 127 × −128 → 0xC080.
  - 0 × −1 → 0x0000.
- **Non-power-of-two width, NB_DATA=5:**
  - 31 × 31 unsigned → 0x3C1, o_valid exactly 5 cycles after acceptance.
  - −16 × −16 signed → 0x100.
  - Exhaustive random sweep against a reference model.
- **Backpressure:**
  - Hold i_ready = 0 for 5 cycles in DONE → o_product stable, o_ready stays 0.
  - Pulse i_valid during MULT with different operands → ignored.
  - Raise i_ready → IDLE next cycle.
- **Abort:**
  - Assert i_clear at step 3 of 8 → IDLE next edge, o_valid never asserts, o_product = 0.
  - Assert i_clear and i_valid together in IDLE → no acceptance.
- **Async reset and back-to-back:**
  - Assert i_rst mid-MULT between edges → outputs return to reset values immediately.
  - After reset, two back-to-back operations with i_ready tied high → both correct, spaced NB_DATA+2 cycles apart.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Ports: i_clk, i_rst (async high), i_clear (sync abort),
//   i_valid/o_ready/i_a/i_b/i_signed operand side,
//   o_valid/i_ready/o_product result side, o_busy while stepping.
module shift_add_mult #(
  parameter int NB_DATA = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NB_DATA-1:0]     i_a,
  input  logic [NB_DATA-1:0]     i_b,
  input  logic                   i_signed,
  output logic                   o_busy,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [2*NB_DATA-1:0]   o_product
);

  localparam int NB_CNT = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t               state;
  logic [NB_DATA-1:0]   mcand;
  logic [NB_DATA-1:0]   mplier;
  logic [2*NB_DATA-1:0] acc;
  logic                 neg;
  logic [NB_CNT-1:0]    cnt;

  logic [NB_DATA-1:0]   a_mag;
  logic [NB_DATA-1:0]   b_mag;
  logic [NB_DATA-1:0]   addend;
  logic [NB_DATA:0]     sum;
  logic [2*NB_DATA-1:0] acc_nxt;

  // Magnitudes are held unsigned; the most negative value
  // maps onto 2^(NB_DATA-1), which still fits in NB_DATA bits.
  always_comb begin
    a_mag = i_a;
    b_mag = i_b;
    if (i_signed && i_a[NB_DATA-1])
      a_mag = ~i_a + NB_DATA'(1);
    if (i_signed && i_b[NB_DATA-1])
      b_mag = ~i_b + NB_DATA'(1);
    addend = mplier[0] ? mcand : '0;
    sum = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, addend};
    // Carry re-enters at the top as the pair shifts right.
    acc_nxt = {sum, acc[NB_DATA-1:1]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      o_product <= '0;
    end else if (i_clear) begin
      state     <= IDLE;
      cnt       <= '0;
      o_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= i_signed & (i_a[NB_DATA-1] ^ i_b[NB_DATA-1]);
            cnt    <= '0;
            acc    <= '0;
            state  <= MULT;
          end
        end
        MULT: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + NB_CNT'(1);
          if (cnt == LAST) begin
            o_product <= neg ? (~acc_nxt + (2*NB_DATA)'(1))
                             : acc_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          if (i_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state == MULT);
  assign o_valid = (state == DONE);
  assign o_ready = (state == IDLE) && !i_rst;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at widths 8 and 5.
// Ports of both instances driven from one linear sequence.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;

  logic        clr8, vi8, ro8, s8, busy8, vo8, ri8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        clr5, vi5, ro5, s5, busy5, vo5, ri5;
  logic [4:0]  a5, b5;
  logic [9:0]  p5;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.NB_DATA(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr8),
    .i_valid(vi8), .o_ready(ro8), .i_a(a8), .i_b(b8),
    .i_signed(s8), .o_busy(busy8), .o_valid(vo8),
    .i_ready(ri8), .o_product(p8)
  );

  shift_add_mult #(.NB_DATA(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr5),
    .i_valid(vi5), .o_ready(ro5), .i_a(a5), .i_b(b5),
    .i_signed(s5), .o_busy(busy5), .o_valid(vo5),
    .i_ready(ri5), .o_product(p5)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, output logic [15:0] p,
                      output int lat);
    a8 = a; b8 = b; s8 = s; vi8 = 1'b1;
    tick();
    vi8 = 1'b0;
    lat = 0;
    while (!vo8 && lat < 40) begin
      tick();
      lat++;
    end
    chk("run8_done", vo8, 1);
    p = p8;
    ri8 = 1'b1;
    tick();
    ri8 = 1'b0;
  endtask

  task automatic run5(input logic [4:0] a, input logic [4:0] b,
                      input logic s, output logic [9:0] p,
                      output int lat);
    a5 = a; b5 = b; s5 = s; vi5 = 1'b1;
    tick();
    vi5 = 1'b0;
    lat = 0;
    while (!vo5 && lat < 40) begin
      tick();
      lat++;
    end
    chk("run5_done", vo5, 1);
    p = p5;
    ri5 = 1'b1;
    tick();
    ri5 = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] p;
    logic [9:0]  q;
    logic [9:0]  e10;
    logic [15:0] pr [2];
    int          ts [2];
    int          lat, got, ea, eb, prod;
    logic        seen;

    rst = 1'b1;
    clr8 = 0; vi8 = 0; s8 = 0; ri8 = 0; a8 = '0; b8 = '0;
    clr5 = 0; vi5 = 0; s5 = 0; ri5 = 0; a5 = '0; b5 = '0;
    repeat (3) tick();

    chk("rst_ready", ro8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_valid", vo8, 0);
    chk("rst_prod", p8, 0);
    chk("rst_prod5", p5, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", ro8, 1);
    chk("rst_release_ready5", ro5, 1);

    run8(8'hFF, 8'hFF, 1'b0, p, lat);
    chk("u_ff_ff", p, 16'hFE01);
    chk("u_ff_ff_lat", lat, 8);
    run8(8'hFD, 8'h05, 1'b0, p, lat);
    chk("u_fd_05", p, 16'h04F1);

    run8(8'h80, 8'h80, 1'b1, p, lat);
    chk("s_m128_m128", p, 16'h4000);
    run8(8'hFD, 8'h05, 1'b1, p, lat);
    chk("s_m3_5", p, 16'hFFF1);
    run8(8'h7F, 8'h80, 1'b1, p, lat);
    chk("s_127_m128", p, 16'hC080);
    run8(8'h00, 8'hFF, 1'b1, p, lat);
    chk("s_0_m1", p, 16'h0000);

    // Backpressure with an ignored request during MULT
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; vi8 = 1'b1;
    tick();
    vi8 = 1'b0;
    chk("bp_busy", busy8, 1);
    chk("bp_ready_drop", ro8, 0);
    tick();
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1; vi8 = 1'b1;
    tick();
    vi8 = 1'b0;
    lat = 0;
    while (!vo8 && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_valid", vo8, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_prod", p8, 16'h03A8);
      chk("bp_hold_valid", vo8, 1);
      chk("bp_hold_ready", ro8, 0);
    end
    ri8 = 1'b1;
    tick();
    ri8 = 1'b0;
    chk("bp_consumed_valid", vo8, 0);
    chk("bp_consumed_ready", ro8, 1);
    tick();
    chk("bp_no_queued", busy8, 0);

    // Abort after three of eight steps
    a8 = 8'h0F; b8 = 8'h0F; s8 = 1'b0; vi8 = 1'b1;
    tick();
    vi8 = 1'b0;
    repeat (3) tick();
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("clr_ready", ro8, 1);
    chk("clr_busy", busy8, 0);
    chk("clr_valid", vo8, 0);
    chk("clr_prod", p8, 0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (vo8) seen = 1'b1;
    end
    chk("clr_no_valid", seen, 0);
    clr8 = 1'b1; vi8 = 1'b1;
    tick();
    clr8 = 1'b0; vi8 = 1'b0;
    chk("clr_vs_valid_busy", busy8, 0);
    chk("clr_vs_valid_ready", ro8, 1);
    tick();
    chk("clr_vs_valid_idle", busy8, 0);

    // Async reset between edges mid-MULT
    run8(8'h03, 8'h03, 1'b0, p, lat);
    chk("u_3_3", p, 16'h0009);
    a8 = 8'h55; b8 = 8'h33; vi8 = 1'b1;
    tick();
    vi8 = 1'b0;
    repeat (2) tick();
    chk("arst_pre_busy", busy8, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_valid", vo8, 0);
    chk("arst_prod", p8, 0);
    chk("arst_ready", ro8, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_release_ready", ro8, 1);

    // Back-to-back with i_ready tied high
    a8 = 8'h0C; b8 = 8'h0B; s8 = 1'b0; vi8 = 1'b1; ri8 = 1'b1;
    tick();
    a8 = 8'h0A; b8 = 8'h14;
    got = 0;
    ts[0] = 0; ts[1] = 0; pr[0] = '0; pr[1] = '0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      tick();
      if (vo8) begin
        ts[got] = c;
        pr[got] = p8;
        got++;
      end
    end
    vi8 = 1'b0;
    tick();
    ri8 = 1'b0;
    chk("b2b_count", got, 2);
    chk("b2b_first", pr[0], 16'h0084);
    chk("b2b_second", pr[1], 16'h00C8);
    chk("b2b_spacing", ts[1] - ts[0], 10);

    // Width 5
    run5(5'd31, 5'd31, 1'b0, q, lat);
    chk("w5_31_31", q, 10'h3C1);
    chk("w5_lat", lat, 5);
    run5(5'h10, 5'h10, 1'b1, q, lat);
    chk("w5_m16_m16", q, 10'h100);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          run5(5'(a), 5'(b), 1'(s), q, lat);
          ea = (s == 1 && a >= 16) ? a - 32 : a;
          eb = (s == 1 && b >= 16) ? b - 32 : b;
          prod = ea * eb;
          e10 = prod[9:0];
          chk("w5_sweep", q, e10);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
